// File: rtl/lc3_mem_responder_if.sv
// LC-3 control-unit memory handshake bundle. The controller is the master and
// the memory/device responder is the slave.
interface lc3_mem_responder_if;
   logic        memEN;
   logic [15:0] MAR;
   logic [15:0] MDR;
   logic        memWE;
   logic        memRDY;
   logic [15:0] memData;

   modport master (output memEN, MAR, MDR, memWE, input memRDY, memData);
   modport slave  (input memEN, MAR, MDR, memWE, output memRDY, memData);
endinterface

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 control unit: word RAM, keyboard and
// display device registers, and the keyboard interrupt request.
//
// state | meaning
// IDLE  | no access in flight; a high memEN captures MAR and loads the wait counter
// WAIT  | counting wait states; memEN dropping abandons the access
// READY | memRDY high for one cycle; the write (if memWE) commits on the closing edge
module lc3_mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   lc3_mem_responder_if.slave     bus,
   input  logic                   kb_valid,
   input  logic [7:0]             kb_char,
   output logic                   dd_valid,
   output logic [7:0]             dd_char,
   input  logic                   dd_ready,
   output logic                   INT
);

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t      state, stateNext;
   logic [3:0]  cnt, cntNext;
   logic [15:0] addr_q, addrNext;
   logic        enterReady;

   logic [15:0] ram [0:(1 << ADDR_W) - 1];
   logic [15:0] memDataQ;
   logic [15:0] readAddr, readData;

   logic        kbReady, kbIe;
   logic [7:0]  kbdr;

   logic        inReady, commit, kbdrReadDone;

   function automatic logic isRam(input logic [15:0] a);
      return (a >> ADDR_W) == 16'd0;
   endfunction

   assign inReady      = (state == READY);
   assign commit       = inReady && bus.memWE;
   assign kbdrReadDone = inReady && !bus.memWE && (addr_q == KBDR_ADDR);

   assign bus.memRDY  = inReady;
   assign bus.memData = memDataQ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         addr_q <= addrNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      addrNext   = addr_q;
      enterReady = 1'b0;
      case (state)
         IDLE: begin
            if (bus.memEN) begin
               addrNext = bus.MAR;
               cntNext  = WS_LOAD;
               if (WAIT_STATES == 0) begin
                  stateNext  = READY;
                  enterReady = 1'b1;
               end else begin
                  stateNext = WAIT;
               end
            end
         end
         WAIT: begin
            if (!bus.memEN) begin
               stateNext = IDLE;
            end else if (cnt == 4'd1) begin
               stateNext  = READY;
               enterReady = 1'b1;
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         READY:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // With zero wait states READY is entered straight from IDLE, before addr_q holds the address.
   assign readAddr = (state == IDLE) ? bus.MAR : addr_q;

   always_comb begin
      readData = '0;
      if (isRam(readAddr)) begin
         readData = ram[readAddr[ADDR_W-1:0]];
      end else begin
         case (readAddr)
            KBSR_ADDR: readData = {kbReady, kbIe, 14'd0};
            KBDR_ADDR: readData = {8'h00, kbdr};
            DSR_ADDR:  readData = {~dd_valid, 15'd0};
            DDR_ADDR:  readData = {8'h00, dd_char};
            default:   readData = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memDataQ <= '0;
      end else if (enterReady) begin
         memDataQ <= readData;
      end else begin
         memDataQ <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && isRam(addr_q)) begin
         ram[addr_q[ADDR_W-1:0]] <= bus.MDR;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kbReady <= 1'b0;
         kbIe    <= 1'b0;
         kbdr    <= '0;
      end else begin
         // A character arriving as a KBDR read completes replaces the one just read.
         if (kb_valid && (!kbReady || kbdrReadDone)) begin
            kbdr    <= kb_char;
            kbReady <= 1'b1;
         end else if (kbdrReadDone) begin
            kbReady <= 1'b0;
         end
         if (commit && (addr_q == KBSR_ADDR)) begin
            kbIe <= bus.MDR[14];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dd_valid <= 1'b0;
         dd_char  <= '0;
      end else begin
         if (commit && (addr_q == DDR_ADDR) && !dd_valid) begin
            dd_valid <= 1'b1;
            dd_char  <= bus.MDR[7:0];
         end else if (dd_valid && dd_ready) begin
            dd_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         INT <= 1'b0;
      end else begin
         INT <= kbReady & kbIe;
      end
   end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: one instance with two wait states
// carrying the device tests, one with zero wait states for minimum latency.
module tb_lc3_mem_responder;

   typedef struct {
      logic [15:0] data;
      bit          chk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       kb_valid;
   logic [7:0] kb_char;
   logic       dd_valid;
   logic [7:0] dd_char;
   logic       dd_ready;
   logic       INT;

   logic       dd_valid1;
   logic [7:0] dd_char1;
   logic       INT1;

   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   lc3_mem_responder_if bus();
   lc3_mem_responder_if bus0();

   lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .kb_valid (kb_valid),
      .kb_char  (kb_char),
      .dd_valid (dd_valid),
      .dd_char  (dd_char),
      .dd_ready (dd_ready),
      .INT      (INT)
   );

   lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus0.slave),
      .kb_valid (1'b0),
      .kb_char  (8'h00),
      .dd_valid (dd_valid1),
      .dd_char  (dd_char1),
      .dd_ready (1'b1),
      .INT      (INT1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.memRDY === 1'b1) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdy_unexpected actual memRDY=1 required memRDY=0 (no access pending)");
         end else begin
            e0 = q0.pop_front();
            if (e0.chk) begin
               checks++;
               if (bus.memData !== e0.data) begin
                  errors++;
                  $display("FAIL memData actual=%h required=%h", bus.memData, e0.data);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus0.memRDY === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdy0_unexpected actual memRDY=1 required memRDY=0 (no access pending)");
         end else begin
            e1 = q1.pop_front();
            if (e1.chk) begin
               checks++;
               if (bus0.memData !== e1.data) begin
                  errors++;
                  $display("FAIL memData0 actual=%h required=%h", bus0.memData, e1.data);
               end
            end
         end
      end
   end

   task automatic drv(input bit sel, input logic en, input logic [15:0] a,
                      input logic [15:0] d, input logic we);
      if (sel) begin
         bus0.memEN = en; bus0.MAR = a; bus0.MDR = d; bus0.memWE = we;
      end else begin
         bus.memEN = en; bus.MAR = a; bus.MDR = d; bus.memWE = we;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? bus0.memRDY : bus.memRDY;
   endfunction

   // One full handshake; memWE is raised only in the memRDY cycle.
   task automatic access(input bit sel, input logic [15:0] a, input logic [15:0] d,
                         input logic we, input logic [15:0] expRd, input bit doChk,
                         input bit kbAtRdy, input logic [7:0] kbc);
      exp_t e;
      int   n;
      logic got;
      int   lat;
      e.data = expRd;
      e.chk  = doChk;
      if (sel) q1.push_back(e); else q0.push_back(e);
      lat = sel ? 1 : 3;
      @(negedge clk);
      drv(sel, 1'b1, a, d, 1'b0);
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         got = rdy(sel);
      end
      checks++;
      if (!got || n != lat) begin
         errors++;
         $display("FAIL latency addr=%h actual=%0d required=%0d", a, got ? n : -1, lat);
      end
      if (got) begin
         drv(sel, 1'b1, a, d, we);
         if (kbAtRdy) begin
            kb_valid = 1'b1;
            kb_char  = kbc;
         end
      end
      @(posedge clk); #1;
      drv(sel, 1'b0, a, d, 1'b0);
      kb_valid = 1'b0;
      chk("rdy_width", 16'(rdy(sel)), 16'h0000);
   endtask

   task automatic kbPulse(input logic [7:0] c);
      @(negedge clk);
      kb_valid = 1'b1;
      kb_char  = c;
      @(negedge clk);
      kb_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      kb_valid = 1'b0;
      kb_char  = 8'h00;
      dd_ready = 1'b0;
      drv(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drv(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #2;
      chk("rst_memRDY",   16'(bus.memRDY), 16'h0000);
      chk("rst_memData",  bus.memData,     16'h0000);
      chk("rst_INT",      16'(INT),        16'h0000);
      chk("rst_dd_valid", 16'(dd_valid),   16'h0000);
      chk("rst_dd_char",  16'(dd_char),    16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // RAM write then read-back, plus the RAM/unmapped boundary
      access(0, 16'h0010, 16'h1234, 1, 16'h0000, 0, 0, 8'h00);
      access(0, 16'h0010, 16'h0000, 0, 16'h1234, 1, 0, 8'h00);
      access(0, 16'h03FF, 16'hBEEF, 1, 16'h0000, 0, 0, 8'h00);
      access(0, 16'h0400, 16'h1111, 1, 16'h0000, 0, 0, 8'h00);
      access(0, 16'h03FF, 16'h0000, 0, 16'hBEEF, 1, 0, 8'h00);
      access(0, 16'h0400, 16'h0000, 0, 16'h0000, 1, 0, 8'h00);
      access(0, 16'h0010, 16'h5678, 1, 16'h1234, 1, 0, 8'h00);
      access(0, 16'h0010, 16'h0000, 0, 16'h5678, 1, 0, 8'h00);

      // Abort during WAIT
      access(0, 16'h0020, 16'hAAAA, 1, 16'h0000, 0, 0, 8'h00);
      @(negedge clk);
      drv(0, 1'b1, 16'h0020, 16'h5555, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drv(0, 1'b0, 16'h0020, 16'h5555, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_rdy", 16'(bus.memRDY), 16'h0000);
      end
      drv(0, 1'b0, 16'h0020, 16'h5555, 1'b0);
      access(0, 16'h0020, 16'h0000, 0, 16'hAAAA, 1, 0, 8'h00);

      // Keyboard
      kbPulse(8'h41);
      access(0, 16'hFE00, 16'h4000, 1, 16'h0000, 0, 0, 8'h00);
      @(posedge clk); #1;
      chk("int_set", 16'(INT), 16'h0001);
      access(0, 16'hFE02, 16'h0000, 0, 16'h0041, 1, 0, 8'h00);
      @(posedge clk); #1;
      chk("int_clear", 16'(INT), 16'h0000);
      access(0, 16'hFE00, 16'h0000, 0, 16'h4000, 1, 0, 8'h00);
      kbPulse(8'h42);
      kbPulse(8'h44);
      access(0, 16'hFE02, 16'h0000, 0, 16'h0042, 1, 1, 8'h43);
      access(0, 16'hFE00, 16'h0000, 0, 16'hC000, 1, 0, 8'h00);
      access(0, 16'hFE02, 16'h0000, 0, 16'h0043, 1, 0, 8'h00);
      access(0, 16'hFE02, 16'h0099, 1, 16'h0000, 0, 0, 8'h00);
      access(0, 16'hFE00, 16'h0000, 0, 16'h4000, 1, 0, 8'h00);

      // Display
      access(0, 16'hFE06, 16'h0058, 1, 16'h0000, 0, 0, 8'h00);
      chk("dd_valid_set", 16'(dd_valid), 16'h0001);
      chk("dd_char_set",  16'(dd_char),  16'h0058);
      access(0, 16'hFE04, 16'h0000, 0, 16'h0000, 1, 0, 8'h00);
      access(0, 16'hFE06, 16'h0059, 1, 16'h0000, 0, 0, 8'h00);
      chk("dd_char_drop", 16'(dd_char), 16'h0058);
      access(0, 16'hFE06, 16'h0000, 0, 16'h0058, 1, 0, 8'h00);
      @(negedge clk);
      dd_ready = 1'b1;
      @(posedge clk); #1;
      dd_ready = 1'b0;
      chk("dd_valid_clear", 16'(dd_valid), 16'h0000);
      access(0, 16'hFE04, 16'h0000, 0, 16'h8000, 1, 0, 8'h00);

      // Unmapped
      access(0, 16'h8000, 16'hFFFF, 1, 16'h0000, 0, 0, 8'h00);
      access(0, 16'h8000, 16'h0000, 0, 16'h0000, 1, 0, 8'h00);

      // Zero wait states
      access(1, 16'h0005, 16'h0BAD, 1, 16'h0000, 0, 0, 8'h00);
      access(1, 16'h0005, 16'h0000, 0, 16'h0BAD, 1, 0, 8'h00);
      access(1, 16'hFE04, 16'h0000, 0, 16'h8000, 1, 0, 8'h00);

      // Reset in the middle of a write access
      access(0, 16'h0030, 16'h0001, 1, 16'h0000, 0, 0, 8'h00);
      kbPulse(8'h45);
      access(0, 16'hFE06, 16'h005A, 1, 16'h0000, 0, 0, 8'h00);
      chk("pre_rst_INT",      16'(INT),      16'h0001);
      chk("pre_rst_dd_valid", 16'(dd_valid), 16'h0001);
      @(negedge clk);
      drv(0, 1'b1, 16'h0030, 16'h7777, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_memRDY",   16'(bus.memRDY), 16'h0000);
      chk("mid_rst_INT",      16'(INT),        16'h0000);
      chk("mid_rst_dd_valid", 16'(dd_valid),   16'h0000);
      drv(0, 1'b0, 16'h0030, 16'h7777, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      access(0, 16'h0030, 16'h0000, 0, 16'h0001, 1, 0, 8'h00);
      access(0, 16'hFE00, 16'h0000, 0, 16'h0000, 1, 0, 8'h00);
      access(0, 16'hFE04, 16'h0000, 0, 16'h8000, 1, 0, 8'h00);

      repeat (3) @(negedge clk);
      chk("q0_drained", 16'(q0.size()), 16'h0000);
      chk("q1_drained", 16'(q1.size()), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 control unit's memory handshake.
- Accepts a request from MAR/MDR/memWE and returns memRDY after a fixed number of wait states, with read data on memData.
- Backs a word-addressed RAM plus the LC-3 keyboard and display device registers.
- Generates the keyboard interrupt request that feeds the control unit's INT input.

Parameters:
ADDR_W, 10, number of RAM address bits; addresses below 2**ADDR_W map to RAM.
WAIT_STATES, 2, idle cycles between request capture and memRDY; legal range 0..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
memEN  in  1  access request; held high by the controller until memRDY
MAR  in  16  word address
MDR  in  16  write data
memWE  in  1  write strobe; sampled only in the memRDY cycle
memRDY  out  1  one-cycle access-complete strobe
memData  out  16  read data; valid while memRDY=1
kb_valid  in  1  one-cycle strobe: new keyboard character
kb_char  in  8  keyboard character
dd_valid  out  1  display character pending
dd_char  out  8  display character
dd_ready  in  1  display accepts dd_char when dd_valid=1 and dd_ready=1
INT  out  1  keyboard interrupt request

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; memRDY=0, memData=0, dd_valid=0, dd_char=0, INT=0.
  - KBSR ready and KBSR IE cleared; KBDR=0.
  - RAM contents are not reset.
  - Reset asserted mid-access abandons the access; no write occurs.
- FSM states: IDLE, WAIT, READY.
  - IDLE, memEN=1: capture MAR into addr_q and load cnt=WAIT_STATES. Go to READY if WAIT_STATES=0, else WAIT.
  - WAIT: decrement cnt; go to READY when cnt=1. If memEN drops, abort to IDLE with no memRDY and no side effects.
  - READY: memRDY=1 for exactly one cycle, then IDLE unconditionally. At least one IDLE cycle separates accesses.
- Latency: memEN first seen high at edge k gives memRDY high in cycle k+WAIT_STATES+1.
- memData is registered on entry to READY from the address in addr_q; it is 0 outside READY.
- A write commits on the edge that ends READY, only if memWE=1 in that cycle. memWE in any other state is ignored.
- Address map for addr_q:
  - RAM: addr < 2**ADDR_W. Read-modify semantics: a read returns the old word.
  - xFE00 KBSR: bit15=kb ready (read-only), bit14=IE (read/write); other bits read 0.
  - xFE02 KBDR: reads {8'h00, char}. A completed read clears kb ready. Writes are ignored.
  - xFE04 DSR: bit15 = ~dd_valid; other bits read 0. Writes are ignored.
  - xFE06 DDR: a write with dd_valid=0 sets dd_valid=1 and dd_char=MDR[7:0]. A write with dd_valid=1 is dropped. Reads return {8'h00, dd_char}.
  - Any other address: reads 0, writes ignored.
- Keyboard input:
  - kb_valid with kb ready=0: latch kb_char and set ready.
  - kb_valid with kb ready=1: drop the character.
  - kb_valid in the same cycle as a completing KBDR read: the read returns the old char, the new char is latched, and ready stays 1.
- Display output: dd_valid clears on the edge where dd_valid=1 and dd_ready=1.
- INT is registered: INT <= KBSR[15] & KBSR[14]. It deasserts the cycle after a KBDR read clears ready.

Test Plan:
- WAIT_STATES=2: memEN=1, MAR=x0010, memWE=1 on the memRDY cycle, MDR=x1234; then read x0010 -> memRDY 3 cycles after request, memData=x1234, memRDY width 1.
- Abort: memEN drops during WAIT with memWE=1, MAR=x0020 -> no memRDY; x0020 keeps its old value.
- Keyboard: kb_valid with kb_char=x41, then write KBSR=x4000 -> INT=1; read KBDR returns x0041; INT=0 next cycle; KBSR reads x4000.
- Display: with dd_ready=0, write DDR=x0058 -> dd_valid=1, dd_char=x58, DSR reads x0000; second DDR write x0059 is dropped; dd_ready=1 -> dd_valid=0, DSR reads x8000.
- Unmapped: write x8000, then read x8000 -> memData=x0000. WAIT_STATES=0 gives memRDY 1 cycle after request.
- Reset mid-WAIT with memWE=1: rst low -> memRDY=0, INT=0, dd_valid=0 immediately; after release, the next access completes normally.
